// File: rtl/rst_mp_if.sv
// rtl/rst_mp_if.sv - dispatch/writeback/lookup bundle for the register status table
interface rst_mp_if #(
  parameter int NREGS = 16,
  parameter int TAG_W = 4,
  parameter int NWB   = 2,
  parameter int NRD   = 2
);
  localparam int SEL_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS + 1);

  logic                   flush;
  logic                   di_write;
  logic [SEL_W-1:0]       di_sel;
  logic [TAG_W-1:0]       di_tag;
  logic [NWB-1:0]         wb_write;
  logic [NWB*SEL_W-1:0]   wb_sel;
  logic [NWB*TAG_W-1:0]   wb_tag;
  logic [NRD*SEL_W-1:0]   rd_sel;
  logic [NRD-1:0]         rd_busy;
  logic [NRD*TAG_W-1:0]   rd_tag;
  logic [CNT_W-1:0]       busy_cnt;
  logic                   full;

  modport master (
    output flush, di_write, di_sel, di_tag, wb_write, wb_sel, wb_tag, rd_sel,
    input  rd_busy, rd_tag, busy_cnt, full
  );

  modport slave (
    input  flush, di_write, di_sel, di_tag, wb_write, wb_sel, wb_tag, rd_sel,
    output rd_busy, rd_tag, busy_cnt, full
  );
endinterface

// File: rtl/rst_mp.sv
// rtl/rst_mp.sv - multi-port register status table; RST_MP_WB_BYPASS_EN forwards writebacks to lookups
module rst_mp #(
  parameter int NREGS = 16,
  parameter int TAG_W = 4,
  parameter int NWB   = 2,
  parameter int NRD   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  rst_mp_if.slave     bus
);
  localparam int SEL_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS + 1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [TAG_W-1:0] tag_d [NREGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0] wb_hit;

  // Per entry: does any writeback port retire the current rename of this register
  always_comb begin
    wb_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < NWB; k++) begin
        if (bus.wb_write[k] && bus.wb_sel[k*SEL_W +: SEL_W] == SEL_W'(r) &&
            busy_q[r] && tag_q[r] == bus.wb_tag[k*TAG_W +: TAG_W]) begin
          wb_hit[r] = 1'b1;
        end
      end
    end
  end

  // Next state: flush, then dispatch (newer rename beats old writeback), then tag-matched clear
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (bus.flush) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end else if (bus.di_write && bus.di_sel == SEL_W'(r)) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = bus.di_tag;
      end else if (wb_hit[r]) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  // Table and busy count registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NREGS; r++) tag_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      for (int r = 0; r < NREGS; r++) tag_q[r] <= tag_d[r];
    end
  end

  // Lookup ports: selects that match no entry (out of range) read as idle
  always_comb begin
    bus.rd_busy = '0;
    bus.rd_tag  = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.rd_sel[i*SEL_W +: SEL_W] == SEL_W'(r) && busy_q[r]) begin
`ifdef RST_MP_WB_BYPASS_EN
          if (!wb_hit[r]) begin
            bus.rd_busy[i]                = 1'b1;
            bus.rd_tag[i*TAG_W +: TAG_W]  = tag_q[r];
          end
`else
          bus.rd_busy[i]                  = 1'b1;
          bus.rd_tag[i*TAG_W +: TAG_W]    = tag_q[r];
`endif
        end
      end
    end
  end

  assign bus.busy_cnt = cnt_q;
  assign bus.full     = (cnt_q == CNT_W'(NREGS));
endmodule
